// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings and per-state control word for mc_control (honours MC_CONTROL_ILLEGAL_TRAP_EN)
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_J,
    CLS_ADDI,
    CLS_BAD
  } cls_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       adv;
    logic       branch;
    logic       jump;
    logic       ir_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Control word for a (state, class) pair; the advance strobe marks the last state of each class path.
  function automatic ctrl_t ctrl_for(input state_e st, input cls_e cls);
    ctrl_t c;
    c = '0;
    case (st)
      S_IF: c.ir_write = 1'b1;
      S_ID: begin
        if (cls == CLS_J) begin
          c.adv  = 1'b1;
          c.jump = 1'b1;
        end
`ifndef MC_CONTROL_ILLEGAL_TRAP_EN
        if (cls == CLS_BAD) c.adv = 1'b1;
`endif
      end
      S_EX: begin
        case (cls)
          CLS_R: c.alu_op = ALUOP_FUNCT;
          CLS_BR: begin
            c.alu_op = ALUOP_SUB;
            c.adv    = 1'b1;
            c.branch = 1'b1;
          end
          CLS_LW, CLS_SW, CLS_ADDI: begin
            c.alu_op  = ALUOP_ADD;
            c.alu_src = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        c.mem_read  = (cls == CLS_LW);
        c.mem_write = (cls == CLS_SW);
        c.adv       = (cls == CLS_SW);
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.adv        = 1'b1;
        c.reg_dst    = (cls == CLS_R);
        c.mem_to_reg = (cls == CLS_LW);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - run/instruction inputs and control outputs of mc_control
interface mc_control_if;
  logic        over;
  logic        sortover;
  logic [31:0] inst;
  logic        IF;
  logic        Branch;
  logic        Jump;
  logic        IRWrite;
  logic        RegDst;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    output over, sortover, inst,
    input  IF, Branch, Jump, IRWrite, RegDst, ALUSrc, ALUOp,
    input  MemRead, MemWrite, MemtoReg, RegWrite, state, illegal
  );

  modport slave (
    input  over, sortover, inst,
    output IF, Branch, Jump, IRWrite, RegDst, ALUSrc, ALUOp,
    output MemRead, MemWrite, MemtoReg, RegWrite, state, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode to instruction-class decoder
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_e       cls
);

  // Map the opcode onto the class that selects the FSM path.
  always_comb begin
    cls = CLS_BAD;
    case (opcode)
      OP_R:           cls = CLS_R;
      OP_LW:          cls = CLS_LW;
      OP_SW:          cls = CLS_SW;
      OP_BEQ, OP_BNE: cls = CLS_BR;
      OP_J:           cls = CLS_J;
      OP_ADDI:        cls = CLS_ADDI;
      default:        cls = CLS_BAD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle control FSM with registered outputs; MC_CONTROL_ILLEGAL_TRAP_EN traps unknown opcodes in S_HALT
module mc_control
  import mc_pkg::*;
(
  input  logic         Clk,
  input  logic         Clr,
  mc_control_if.slave  bus
);

  state_e state_q, state_d;
  state_e boundary;
  cls_e   cls_q, cls_d, dec_cls;
  ctrl_t  ctrl_q, ctrl_d;
  logic   start_ok;
  logic   unused_inst;

  assign start_ok    = bus.over & ~bus.sortover;
  assign unused_inst = ^bus.inst[25:0];

  mc_decode u_decode (
    .opcode (bus.inst[31:26]),
    .cls    (dec_cls)
  );

  // Next state, held class and the control word of the state being entered.
  always_comb begin
    boundary = start_ok ? S_IF : S_IDLE;
    state_d  = state_q;
    cls_d    = cls_q;
    case (state_q)
      S_IDLE: state_d = boundary;
      S_IF: begin
        state_d = S_ID;
        cls_d   = dec_cls;
      end
      S_ID: begin
        case (cls_q)
          CLS_J: state_d = boundary;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
          CLS_BAD: state_d = S_HALT;
`else
          CLS_BAD: state_d = boundary;
`endif
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls_q)
          CLS_LW, CLS_SW:  state_d = S_MEM;
          CLS_R, CLS_ADDI: state_d = S_WB;
          default:         state_d = boundary;
        endcase
      end
      S_MEM: state_d = (cls_q == CLS_SW) ? boundary : S_WB;
      S_WB:  state_d = boundary;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
    ctrl_d = ctrl_for(state_d, cls_d);
  end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d   = (state_d == S_HALT);
  assign bus.illegal = illegal_q;

  // Trap flag follows the halt state so it shares the registered-output timing.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
`else
  assign bus.illegal = 1'b0;
`endif

  // State, class and control outputs; Clr clears everything without waiting for Clk.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= S_IDLE;
      cls_q   <= CLS_R;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.IF       = ctrl_q.adv;
  assign bus.Branch   = ctrl_q.branch;
  assign bus.Jump     = ctrl_q.jump;
  assign bus.IRWrite  = ctrl_q.ir_write;
  assign bus.RegDst   = ctrl_q.reg_dst;
  assign bus.ALUSrc   = ctrl_q.alu_src;
  assign bus.ALUOp    = ctrl_q.alu_op;
  assign bus.MemRead  = ctrl_q.mem_read;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed and randomized bench for mc_control against a path-queue model (MC_CONTROL_ILLEGAL_TRAP_EN aware)
module tb_mc_control;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_ADDI = 5, C_BAD = 6;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [31:0] I_LW  = 32'h8C010004;
  localparam logic [31:0] I_BEQ = 32'h10220003;
  localparam logic [31:0] I_J   = 32'h08000005;
  localparam logic [31:0] I_RT  = 32'h00221820;
  localparam logic [31:0] I_BAD = 32'hFC000000;

  int m_state;
  int m_cls;
  int m_rest[$];

  function automatic int classify(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    case (op)
      6'd0:  return C_R;
      6'd35: return C_LW;
      6'd43: return C_SW;
      6'd4:  return C_BR;
      6'd5:  return C_BR;
      6'd2:  return C_J;
      6'd8:  return C_ADDI;
      default: return C_BAD;
    endcase
  endfunction

  task automatic model_edge();
    bit go;
    go = bus.over && !bus.sortover;
    if (m_state == 0) begin
      m_state = go ? 1 : 0;
    end else if (m_state == 1) begin
      m_cls   = classify(bus.inst);
      m_state = 2;
      case (m_cls)
        C_LW:         m_rest = {3, 4, 5};
        C_SW:         m_rest = {3, 4};
        C_R, C_ADDI:  m_rest = {3, 5};
        C_BR:         m_rest = {3};
        C_BAD:        if (TRAP) m_rest = {6}; else m_rest = {};
        default:      m_rest = {};
      endcase
    end else if (m_state == 6) begin
      m_state = 6;
    end else if (m_rest.size() > 0) begin
      m_state = m_rest.pop_front();
    end else begin
      m_state = go ? 1 : 0;
    end
  endtask

  function automatic logic [15:0] exp_word();
    bit last, ex, wb, mem;
    logic [1:0] aop;
    last = (m_state >= 2) && (m_state <= 5) && (m_rest.size() == 0);
    ex   = (m_state == 3);
    mem  = (m_state == 4);
    wb   = (m_state == 5);
    aop  = !ex ? 2'd0 : (m_cls == C_R) ? 2'd2 : (m_cls == C_BR) ? 2'd1 : 2'd0;
    return {3'(m_state), last, last && m_cls == C_BR, last && m_cls == C_J, m_state == 1,
            wb && m_cls == C_R, ex && (m_cls == C_LW || m_cls == C_SW || m_cls == C_ADDI), aop,
            mem && m_cls == C_LW, mem && m_cls == C_SW, wb && m_cls == C_LW, wb, m_state == 6};
  endfunction

  function automatic logic [15:0] dut_word();
    return {bus.state, bus.IF, bus.Branch, bus.Jump, bus.IRWrite, bus.RegDst, bus.ALUSrc,
            bus.ALUOp, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite, bus.illegal};
  endfunction

  task automatic cycle(input bit o, input bit s, input logic [31:0] w, input string tag);
    bus.over     = o;
    bus.sortover = s;
    bus.inst     = w;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag, 32'(dut_word()), 32'(exp_word()));
  endtask

  task automatic do_clr();
    #2 clr = 1'b1;
    #1 check("clr_async", 32'(dut_word()), 32'h0);
    m_state = 0;
    m_rest  = {};
    @(posedge clk);
    @(negedge clk);
    check("clr_hold", 32'(dut_word()), 32'h0);
    clr = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd0};
    ops[7] = 6'($urandom_range(0, 63));
    op = ops[$urandom_range(0, 7)];
    return {op, 26'($urandom)};
  endfunction

  initial begin
    clr          = 1'b1;
    bus.over     = 1'b0;
    bus.sortover = 1'b0;
    bus.inst     = 32'h0;
    m_state      = 0;
    m_cls        = C_R;
    #1 check("reset_state", 32'(dut_word()), 32'h0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;

    // lw: IF, ID, EX, MEM, WB
    cycle(1, 0, I_LW, "lw_c1"); check("lw_s1", 32'(bus.state), 32'd1);
    cycle(1, 0, I_LW, "lw_c2"); check("lw_s2", 32'(bus.state), 32'd2);
    cycle(1, 0, I_LW, "lw_c3"); check("lw_s3", 32'(bus.state), 32'd3);
    cycle(1, 0, I_LW, "lw_c4"); check("lw_memread", 32'({bus.state, bus.MemRead}), 32'h9);
    cycle(1, 0, I_LW, "lw_c5"); check("lw_wb", 32'({bus.state, bus.RegWrite, bus.MemtoReg, bus.IF}), 32'h2F);

    // beq: strobe only in EX
    cycle(1, 0, I_BEQ, "beq_c1");
    cycle(1, 0, I_BEQ, "beq_c2"); check("beq_c2_nobranch", 32'({bus.IF, bus.Branch}), 32'h0);
    cycle(1, 0, I_BEQ, "beq_c3"); check("beq_c3_strobe", 32'({bus.IF, bus.Branch, bus.ALUOp}), 32'hD);

    // j: strobe in ID, then straight into the next fetch
    cycle(1, 0, I_J, "j_c1");
    cycle(1, 0, I_J, "j_c2"); check("j_c2_strobe", 32'({bus.IF, bus.Jump}), 32'h3);

    // R-type with over dropping during EX
    cycle(1, 0, I_RT, "r_c1"); check("j_next_if", 32'(bus.state), 32'd1);
    cycle(1, 0, I_RT, "r_c2");
    cycle(1, 0, I_RT, "r_c3"); check("r_ex_aluop", 32'(bus.ALUOp), 32'h2);
    cycle(0, 0, I_RT, "r_c4"); check("r_wb_done", 32'({bus.state, bus.RegWrite, bus.IF}), 32'h17);
    cycle(0, 0, I_RT, "r_c5"); check("r_idle", 32'(bus.state), 32'd0);
    for (int k = 0; k < 3; k++) cycle(1, 1, I_RT, "sortover_c");
    check("sortover_idle", 32'(bus.state), 32'd0);

    // Clr in the middle of lw MEM
    cycle(1, 0, I_LW, "lwc_c1");
    cycle(1, 0, I_LW, "lwc_c2");
    cycle(1, 0, I_LW, "lwc_c3");
    cycle(1, 0, I_LW, "lwc_c4"); check("lwc_mem", 32'(bus.state), 32'd4);
    do_clr();

    // unknown opcode
    cycle(1, 0, I_BAD, "bad_c1");
    cycle(1, 0, I_BAD, "bad_c2");
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    check("bad_c2_noadv", 32'({bus.state, bus.IF}), 32'h4);
    cycle(1, 0, I_BAD, "bad_c3"); check("bad_halt", 32'({bus.state, bus.illegal, bus.IF}), 32'h1A);
    for (int k = 0; k < 3; k++) cycle(1, 0, I_LW, "halt_hold");
    check("halt_stays", 32'(bus.state), 32'd6);
    do_clr();
`else
    check("bad_c2_nop", 32'({bus.state, bus.IF, bus.illegal}), 32'hA);
    cycle(1, 0, I_BAD, "bad_c3"); check("bad_next_if", 32'(bus.state), 32'd1);
`endif

    // randomized traffic with occasional Clr
    for (int k = 0; k < 3000; k++) begin
      if ((m_state == 6) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0))
        do_clr();
      else
        cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, rand_inst(), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL use one clock and one reset: Clk is the single clock; Clr is an asynchronous, active-high reset.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- Clk  in  1  rising-edge clock
- Clr  in  1  async active-high reset
- over  in  1  run enable
- sortover  in  1  program-complete flag from the PC stage
- inst  in  32  current instruction word (opcode = inst[31:26], funct = inst[5:0])
- IF  out  1  PC-advance strobe to the PC stage
- Branch  out  1  conditional branch (beq/bne)
- Jump  out  1  unconditional jump
- IRWrite  out  1  latch instruction register
- RegDst  out  1  dest = rd (1) / rt (0)
- ALUSrc  out  1  ALU B = sign-extended imm
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- MemRead  out  1  data memory read
- MemWrite  out  1  data memory write
- MemtoReg  out  1  writeback from memory
- RegWrite  out  1  register file write
- state  out  3  current FSM state, for debug/display
- illegal  out  1  unknown opcode trapped (macro-dependent)

Function
REQ-003 SHALL implement a Moore FSM with states S_IDLE=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5, S_HALT=6.
REQ-004 SHALL go from S_IDLE to S_IF when over=1 and sortover=0; otherwise it stays in S_IDLE.
REQ-005 SHALL go from S_IF to S_ID unconditionally, with IRWrite=1 in S_IF only.
REQ-006 SHALL decode only in S_ID and hold each decoded class constant until the next S_IF. Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, j=000010, addi=001000.
REQ-007 SHALL follow these state paths per class:
- j: IF,ID (2 cycles)
- beq/bne: IF,ID,EX (3 cycles)
- R/addi: IF,ID,EX,WB (4 cycles)
- sw: IF,ID,EX,MEM (4 cycles)
- lw: IF,ID,EX,MEM,WB (5 cycles)
REQ-008 SHALL assert IF for exactly one cycle, in the final state of each instruction. Branch or Jump SHALL be asserted in that same cycle and deasserted in every other cycle.
REQ-009 SHALL set datapath controls per state:
- EX: ALUOp=10 for R; 01 for beq/bne; 00 for lw/sw/addi. ALUSrc=1 for lw/sw/addi.
- MEM: MemRead=1 for lw; MemWrite=1 for sw.
- WB: RegWrite=1; RegDst=1 for R only; MemtoReg=1 for lw only.
- All control outputs SHALL be 0 in any state/class combination not listed.
REQ-010 SHALL, after the final state of an instruction, go to S_IF if over=1 and sortover=0, else to S_IDLE. A fall of over mid-instruction SHALL NOT abort the current instruction.
REQ-011 SHALL ignore sortover rising mid-instruction until the instruction boundary.
REQ-012 SHALL handle an unknown opcode per REQ-016/REQ-017.

Reset
REQ-013 SHALL, on Clr=1, immediately force state=S_IDLE and all outputs to 0, independent of Clk.
REQ-014 SHALL, on Clr=1 mid-instruction, abandon the instruction with no further strobes. The first S_IF after Clr deasserts SHALL occur no earlier than one Clk edge later.

Configuration
REQ-015 SHALL use the macro MC_CONTROL_ILLEGAL_TRAP_EN.
REQ-016 SHALL, with MC_CONTROL_ILLEGAL_TRAP_EN defined, move from S_ID to S_HALT on an unknown opcode. In S_HALT it SHALL assert illegal=1 and IF=0 and remain there until Clr.
REQ-017 SHALL, without MC_CONTROL_ILLEGAL_TRAP_EN, treat an unknown opcode as a NOP: IF=1 in S_ID, then proceed per REQ-010. illegal SHALL be tied to 0 and S_HALT SHALL be unreachable.

Structure
REQ-018 SHALL take the opcode constants, the 3-bit state encoding and the ALUOp encodings from the shared package mc_pkg.
REQ-019 SHALL place opcode-to-class decoding in a combinational sub-module mc_decode, instantiated once inside mc_control.

Verification
REQ-020 SHALL cover, as directed bench scenarios:
- Reset, then over=1, inst=0x8C010004 (lw) -> states 1,2,3,4,5; MemRead=1 at cycle 4; RegWrite=1 and MemtoReg=1 with IF=1 at cycle 5.
- inst=0x10220003 (beq) -> IF=1 and Branch=1 together at cycle 3 only; ALUOp=01 at cycle 3.
- inst=0x08000005 (j) -> IF=1 and Jump=1 at cycle 2; next state S_IF.
- over falls during the EX cycle of an R-type (0x00221820) -> WB completes with RegWrite=1 and IF=1, then S_IDLE; sortover=1 at a boundary -> stays S_IDLE.
- Clr pulse during lw S_MEM -> state=0 and all outputs 0 before the next Clk edge.
- inst opcode 111111 -> with the macro: S_HALT, illegal=1, stays until Clr; without the macro: IF=1 at cycle 2, then S_IF.
